vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
// - Pixel-clock-domain raster timing generator for the VGA path. Driven by the 65 MHz
//   vga_pll output clock; qualifies the PLL locked flag and then produces 1024x768@60
//   hsync/vsync/data-enable and pixel coordinates.
// - Also issues frame-buffer fetch requests FETCH_LEAD cycles ahead of active video.
// PARAMETERS
// - H_ACTIVE 1024 / H_FP 24 / H_SYNC 136 / H_BP 160 : horizontal segments, in pixels (H_TOTAL 1344)
// - V_ACTIVE 768 / V_FP 3 / V_SYNC 6 / V_BP 29 : vertical segments, in lines (V_TOTAL 806)
// - HS_POL 0, VS_POL 0 : active level of the sync pulses (0 = active-low)
// - CW 11 : width of the coordinate counters
// - LOCK_STABLE 1024 : consecutive locked cycles required before the raster starts
// - FETCH_LEAD 2 : fetch request lead over de; legal range 1..H_BP
// PORTS
// - clk          in   1  pixel clock, from vga_pll outclk_0
// - rst_n        in   1  synchronous, active-low reset
// - pll_locked   in   1  vga_pll locked flag; synchronised internally with a 2-flop synchroniser
// - enable       in   1  raster enable; sampled only at the frame boundary
// - hsync        out  1  horizontal sync
// - vsync        out  1  vertical sync
// - de           out  1  active-video data enable
// - pos_x        out  CW horizontal position, 0..H_TOTAL-1
// - pos_y        out  CW vertical position, 0..V_TOTAL-1
// - frame_start  out  1  1-cycle pulse when (pos_x,pos_y)=(0,0)
// - fetch_req    out  1  fetch strobe for pixel (fetch_x,fetch_y)
// - fetch_x      out  CW address of the pixel being fetched
// - fetch_y      out  CW address of the pixel being fetched
// - running      out  1  high while in state RUN
// BEHAVIOUR
// - Reset values (rst_n=0): state=WAIT_LOCK; pos_x=pos_y=0; de=fetch_req=frame_start=running=0;
//   hsync=~HS_POL; vsync=~VS_POL; fetch_x=fetch_y=0.
// - All outputs are registered. Every output in a given cycle describes the same (pos_x,pos_y).
// - States:
//   - WAIT_LOCK: go to STABLE when the synchronised lock is 1; clear the stable counter.
//   - STABLE: count up while lock=1. Lock=0 -> WAIT_LOCK. Count reaches LOCK_STABLE-1 and
//     enable=1 -> RUN.
//   - RUN: advance the raster counters every cycle.
//   - While in WAIT_LOCK or STABLE, outputs hold their reset values.
// - Counters: pos_x increments every cycle and wraps H_TOTAL-1 -> 0. On that wrap, pos_y increments
//   and wraps V_TOTAL-1 -> 0. The first RUN cycle presents (0,0) with frame_start=1.
// - de = (pos_x < H_ACTIVE) && (pos_y < V_ACTIVE).
// - hsync is at HS_POL for H_ACTIVE+H_FP <= pos_x < H_ACTIVE+H_FP+H_SYNC.
// - vsync is at VS_POL for V_ACTIVE+V_FP <= pos_y < V_ACTIVE+V_FP+V_SYNC. vsync changes only in
//   cycles where pos_x=0.
// - Fetch: fetch_req=1 exactly FETCH_LEAD cycles before each de=1 cycle.
//   - fetch_x/fetch_y equal the pos_x/pos_y that de will show at that later cycle.
//   - The lead wraps across line and frame ends: a line's first fetch is issued during the
//     previous line's back porch, and pixel (0,0) is fetched at the end of line V_TOTAL-1.
//   - The very first frame after entering RUN omits fetches for pixels 0..FETCH_LEAD-1 of line 0.
// - enable=0 during RUN: the current frame completes. At the (H_TOTAL-1,V_TOTAL-1) -> (0,0)
//   transition the block enters STABLE with its counter saturated, and re-enters RUN on the first
//   cycle that enable=1 again.
// - Lock loss: synchronised lock=0 in any state -> WAIT_LOCK on the next cycle. All outputs return
//   to their reset values in that same cycle, even mid-line or mid-frame; no partial flush.
// - rst_n=0 mid-frame: same behaviour as lock loss, and reset takes priority over every other event.
// - Counter arithmetic is unsigned at CW bits. H_TOTAL and V_TOTAL must each be <= 2^CW (elaboration
//   check). The stable counter is $clog2(LOCK_STABLE+1) bits and saturates.
// STRUCTURE
// - vga_timing_pkg:
//   - localparams for the 1024x768@60 segment defaults and the derived H_TOTAL/V_TOTAL;
//   - the state enum {WAIT_LOCK, STABLE, RUN};
//   - a function that returns whether (x,y) is active.
// - Sub-module vga_lock_qualifier: holds the 2-flop synchroniser and the stable counter, and
//   outputs lock_ok / lock_lost. The raster FSM and counters live in the top module.
// TESTING
// - Small params (H 8/2/2/2, V 4/1/1/1, LOCK_STABLE 4, FETCH_LEAD 2) for fast runs; defaults for a
//   single-frame check.
// - Reset, lock held at 0 for 1000 cycles -> outputs stay at reset values; hsync=vsync=1; running=0.
// - Lock rises -> running=1 exactly 2+LOCK_STABLE cycles later; frame_start=1 with (0,0) in that cycle.
// - Defaults, one full frame:
//   - 1083264 cycles between frame_start pulses;
//   - hsync low for 136 cycles starting at pos_x=1048;
//   - vsync low for lines 771..776;
//   - 786432 de cycles.
// - Fetch check: every de cycle at (x,y) is preceded, FETCH_LEAD cycles earlier, by fetch_req with
//   fetch=(x,y). This includes (0,0) of frame 2, which is fetched at (H_TOTAL-2,V_TOTAL-1) of frame 1.
// - Drop lock at pos=(500,300):
//   - two cycles later all outputs return to reset values;
//   - lock restored -> restart at (0,0) after LOCK_STABLE.
// - enable=0 mid-frame -> frame completes, then running=0.
// - enable=1 again -> running=1 the next cycle, with frame_start=1.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA raster timing generator: 1024x768@60 segment
// defaults, the raster FSM state type and the active-area helper.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE    = 1024;
    localparam int DEF_H_FP        = 24;
    localparam int DEF_H_SYNC      = 136;
    localparam int DEF_H_BP        = 160;
    localparam int DEF_H_TOTAL     = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    localparam int DEF_V_ACTIVE    = 768;
    localparam int DEF_V_FP        = 3;
    localparam int DEF_V_SYNC      = 6;
    localparam int DEF_V_BP        = 29;
    localparam int DEF_V_TOTAL     = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int DEF_CW          = 11;
    localparam int DEF_LOCK_STABLE = 1024;
    localparam int DEF_FETCH_LEAD  = 2;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RUN       = 2'd2
    } vga_state_e;

    // True when (x,y) lies inside the visible picture.
    function automatic logic is_active(input int unsigned x,
                                       input int unsigned y,
                                       input int unsigned h_active,
                                       input int unsigned v_active);
        return (x < h_active) && (y < v_active);
    endfunction

endpackage

// File: rtl/vga_lock_qualifier.sv
// PLL lock qualifier: brings the asynchronous locked flag into the pixel clock
// domain and measures how long it has stayed high.
module vga_lock_qualifier #(
    parameter int LOCK_STABLE = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_locked,
    output logic lock_ok,
    output logic lock_lost
);
    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam logic [SW-1:0] CNT_MAX = SW'(LOCK_STABLE);
    localparam logic [SW-1:0] CNT_OK  = SW'(LOCK_STABLE - 1);
    localparam logic [SW-1:0] CNT_ONE = SW'(1);

    logic          sync_1;
    logic          sync_2;
    logic [SW-1:0] stable_cnt;

    // Two-flop synchroniser for the locked flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= pll_locked;
            sync_2 <= sync_1;
        end
    end

    // Saturating stable counter; any low synchronised lock (which is the whole
    // of the wait-for-lock period) clears it.
    always_ff @(posedge clk) begin
        if (!rst_n || !sync_2) begin
            stable_cnt <= '0;
        end else if (stable_cnt != CNT_MAX) begin
            stable_cnt <= stable_cnt + CNT_ONE;
        end
    end

    assign lock_lost = !sync_2;
    assign lock_ok   = sync_2 && (stable_cnt >= CNT_OK);

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel-clock raster timing generator: qualifies PLL lock, then produces
// hsync/vsync/de, pixel coordinates and look-ahead frame-buffer fetch requests.
// All outputs are registered from the next raster position so that every
// output in a cycle describes the same (pos_x,pos_y).
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int CW          = DEF_CW,
    parameter int LOCK_STABLE = DEF_LOCK_STABLE,
    parameter int FETCH_LEAD  = DEF_FETCH_LEAD
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pll_locked,
    input  logic          enable,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] pos_x,
    output logic [CW-1:0] pos_y,
    output logic          frame_start,
    output logic          fetch_req,
    output logic [CW-1:0] fetch_x,
    output logic [CW-1:0] fetch_y,
    output logic          running
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_TOTAL_C = CW'(H_TOTAL);
    localparam logic [CW-1:0] LEAD_C    = CW'(FETCH_LEAD);
    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW:0]   H_TOTAL_W = (CW+1)'(H_TOTAL);
    localparam logic [CW:0]   LEAD_W    = (CW+1)'(FETCH_LEAD);
    localparam logic [CW:0]   HS_START  = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0]   HS_END    = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0]   VS_START  = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0]   VS_END    = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > (2 ** CW)) begin : g_bad_h_total
        $error("vga_timing_gen: H_TOTAL does not fit the coordinate width");
    end
    if (V_TOTAL > (2 ** CW)) begin : g_bad_v_total
        $error("vga_timing_gen: V_TOTAL does not fit the coordinate width");
    end
    if (FETCH_LEAD < 1 || FETCH_LEAD > H_BP) begin : g_bad_lead
        $error("vga_timing_gen: FETCH_LEAD must lie in 1..H_BP");
    end

    vga_state_e    state;
    vga_state_e    state_nxt;
    logic          lock_ok;
    logic          lock_lost;
    logic          frame_end;
    logic [CW-1:0] nx;
    logic [CW-1:0] ny;
    logic [CW-1:0] lx;
    logic [CW-1:0] ly;
    logic [CW:0]   lx_sum;

    vga_lock_qualifier #(
        .LOCK_STABLE (LOCK_STABLE)
    ) u_lock_qualifier (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .lock_ok    (lock_ok),
        .lock_lost  (lock_lost)
    );

    assign frame_end = (state == RUN) && (pos_x == H_LAST) && (pos_y == V_LAST);

    // Raster FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= WAIT_LOCK;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: lock loss wins everywhere; enable is only honoured at the frame boundary.
    always_comb begin
        state_nxt = state;
        if (lock_lost) begin
            state_nxt = WAIT_LOCK;
        end else begin
            case (state)
                WAIT_LOCK: state_nxt = STABLE;
                STABLE:    if (lock_ok && enable) state_nxt = RUN;
                RUN:       if (frame_end && !enable) state_nxt = STABLE;
                default:   state_nxt = WAIT_LOCK;
            endcase
        end
    end

    // Next raster position, and the position FETCH_LEAD cycles beyond it
    // (wrapping across line and frame ends).
    always_comb begin
        nx = '0;
        ny = '0;
        if (state == RUN) begin
            if (pos_x == H_LAST) begin
                nx = '0;
                ny = (pos_y == V_LAST) ? '0 : pos_y + ONE;
            end else begin
                nx = pos_x + ONE;
                ny = pos_y;
            end
        end
        lx_sum = {1'b0, nx} + LEAD_W;
        if (lx_sum >= H_TOTAL_W) begin
            lx = nx + LEAD_C - H_TOTAL_C;
            ly = (ny == V_LAST) ? '0 : ny + ONE;
        end else begin
            lx = nx + LEAD_C;
            ly = ny;
        end
    end

    // Output registers; they sit at reset values whenever the next state is not RUN.
    always_ff @(posedge clk) begin
        if (!rst_n || state_nxt != RUN) begin
            pos_x       <= '0;
            pos_y       <= '0;
            de          <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            frame_start <= 1'b0;
            fetch_req   <= 1'b0;
            fetch_x     <= '0;
            fetch_y     <= '0;
            running     <= 1'b0;
        end else begin
            pos_x       <= nx;
            pos_y       <= ny;
            de          <= is_active(32'(nx), 32'(ny), H_ACTIVE, V_ACTIVE);
            hsync       <= (({1'b0, nx} >= HS_START) && ({1'b0, nx} < HS_END)) ? HS_POL : ~HS_POL;
            vsync       <= (({1'b0, ny} >= VS_START) && ({1'b0, ny} < VS_END)) ? VS_POL : ~VS_POL;
            frame_start <= (nx == '0) && (ny == '0);
            fetch_req   <= is_active(32'(lx), 32'(ly), H_ACTIVE, V_ACTIVE);
            fetch_x     <= lx;
            fetch_y     <= ly;
            running     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a small-raster instance for lock, frame,
// fetch, lock-loss, enable and reset scenarios, and a default 1024x768
// instance for lock qualification time and first-line timing.
module tb_vga_timing_gen;

    localparam int CW        = 11;
    localparam int S_HA      = 8;
    localparam int S_HFP     = 2;
    localparam int S_HS      = 2;
    localparam int S_HBP     = 2;
    localparam int S_HT      = 14;
    localparam int S_VA      = 4;
    localparam int S_VFP     = 1;
    localparam int S_VS      = 1;
    localparam int S_VBP     = 1;
    localparam int S_VT      = 7;
    localparam int S_FRAME   = S_HT * S_VT;
    localparam int S_LOCK    = 4;
    localparam int S_LEAD    = 2;
    localparam logic [49:0] RST_VEC = {2'b11, 48'd0};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pll_locked;
    logic          enable;
    logic          pll_locked_d;
    logic          enable_d;

    logic          hsync, vsync, de, frame_start, fetch_req, running;
    logic [CW-1:0] pos_x, pos_y, fetch_x, fetch_y;
    logic          hsync_d, vsync_d, de_d, frame_start_d, fetch_req_d, running_d;
    logic [CW-1:0] pos_x_d, pos_y_d, fetch_x_d, fetch_y_d;

    logic [49:0]   small_vec;
    logic [49:0]   def_vec;
    logic [37:0]   exp_q[$];

    int checks = 0;
    int errors = 0;

    assign small_vec = {hsync, vsync, de, frame_start, fetch_req, running, pos_x, pos_y, fetch_x, fetch_y};
    assign def_vec   = {hsync_d, vsync_d, de_d, frame_start_d, fetch_req_d, running_d,
                        pos_x_d, pos_y_d, fetch_x_d, fetch_y_d};

    vga_timing_gen #(
        .H_ACTIVE (S_HA), .H_FP (S_HFP), .H_SYNC (S_HS), .H_BP (S_HBP),
        .V_ACTIVE (S_VA), .V_FP (S_VFP), .V_SYNC (S_VS), .V_BP (S_VBP),
        .HS_POL (1'b0), .VS_POL (1'b0), .CW (CW),
        .LOCK_STABLE (S_LOCK), .FETCH_LEAD (S_LEAD)
    ) dut (
        .clk (clk), .rst_n (rst_n), .pll_locked (pll_locked), .enable (enable),
        .hsync (hsync), .vsync (vsync), .de (de), .pos_x (pos_x), .pos_y (pos_y),
        .frame_start (frame_start), .fetch_req (fetch_req), .fetch_x (fetch_x),
        .fetch_y (fetch_y), .running (running)
    );

    vga_timing_gen dut_def (
        .clk (clk), .rst_n (rst_n), .pll_locked (pll_locked_d), .enable (enable_d),
        .hsync (hsync_d), .vsync (vsync_d), .de (de_d), .pos_x (pos_x_d), .pos_y (pos_y_d),
        .frame_start (frame_start_d), .fetch_req (fetch_req_d), .fetch_x (fetch_x_d),
        .fetch_y (fetch_y_d), .running (running_d)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog timeout");
    end

    task automatic test_reset();
        rst_n = 1'b0; pll_locked = 1'b0; pll_locked_d = 1'b0; enable = 1'b1; enable_d = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (small_vec !== RST_VEC) begin
            errors++; $display("FAIL reset_small: got %h expected %h", small_vec, RST_VEC);
        end
        checks++;
        if (def_vec !== RST_VEC) begin
            errors++; $display("FAIL reset_default: got %h expected %h", def_vec, RST_VEC);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            checks++;
            if (small_vec !== RST_VEC) begin
                errors++; $display("FAIL no_lock_hold cycle %0d: got %h expected %h", i, small_vec, RST_VEC);
            end
        end
    endtask

    // Lock rises in cycle 0; running must appear exactly in cycle 2+LOCK_STABLE.
    task automatic test_lock_start();
        pll_locked = 1'b1;
        for (int k = 1; k <= 2 + S_LOCK; k++) begin
            @(negedge clk);
            if (k < 2 + S_LOCK) begin
                checks++;
                if (small_vec !== RST_VEC) begin
                    errors++; $display("FAIL start_wait cycle %0d: got %h expected %h", k, small_vec, RST_VEC);
                end
            end
        end
        checks++;
        if ({running, frame_start, de, hsync, vsync} !== 5'b11111 || pos_x !== 11'd0 || pos_y !== 11'd0) begin
            errors++;
            $display("FAIL start_first: run/fs/de/hs/vs=%b pos=(%0d,%0d) expected 11111 (0,0)",
                     {running, frame_start, de, hsync, vsync}, pos_x, pos_y);
        end
        checks++;
        if (fetch_req !== 1'b1 || fetch_x !== 11'd2 || fetch_y !== 11'd0) begin
            errors++; $display("FAIL start_fetch: req=%b (%0d,%0d) expected 1 (2,0)", fetch_req, fetch_x, fetch_y);
        end
    endtask

    // Two full small frames against a position model plus fetch/de pairing.
    task automatic test_frame();
        int ex, ey, de_cnt, fs_cnt;
        logic exp_de, exp_hs, exp_vs, exp_fs;
        logic [37:0] e;
        de_cnt = 0; fs_cnt = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 2 * S_FRAME; cyc++) begin
            if (cyc > 0) @(negedge clk);
            ex = cyc % S_HT;
            ey = (cyc / S_HT) % S_VT;
            exp_de = (ex < S_HA) && (ey < S_VA);
            exp_hs = !((ex >= S_HA + S_HFP) && (ex < S_HA + S_HFP + S_HS));
            exp_vs = !((ey >= S_VA + S_VFP) && (ey < S_VA + S_VFP + S_VS));
            exp_fs = (ex == 0) && (ey == 0);
            checks++;
            if (pos_x !== 11'(ex) || pos_y !== 11'(ey)) begin
                errors++; $display("FAIL frame_pos cycle %0d: got (%0d,%0d) expected (%0d,%0d)", cyc, pos_x, pos_y, ex, ey);
            end
            checks++;
            if ({de, hsync, vsync, frame_start, running} !== {exp_de, exp_hs, exp_vs, exp_fs, 1'b1}) begin
                errors++;
                $display("FAIL frame_flags at (%0d,%0d): de/hs/vs/fs/run got %b expected %b", ex, ey,
                         {de, hsync, vsync, frame_start, running}, {exp_de, exp_hs, exp_vs, exp_fs, 1'b1});
            end
            if (ey == S_VT - 1 && ex >= S_HT - S_LEAD) begin
                checks++;
                if (fetch_req !== 1'b1 || fetch_x !== 11'(ex - (S_HT - S_LEAD)) || fetch_y !== 11'd0) begin
                    errors++; $display("FAIL frame_wrap_fetch at (%0d,%0d): req=%b (%0d,%0d) expected 1 (%0d,0)",
                                       ex, ey, fetch_req, fetch_x, fetch_y, ex - (S_HT - S_LEAD));
                end
            end
            if (de === 1'b1) begin
                de_cnt++;
                if (!(cyc < S_FRAME && ey == 0 && ex < S_LEAD)) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++; $display("FAIL fetch_missing at (%0d,%0d): got none expected fetch", ex, ey);
                    end else begin
                        e = exp_q.pop_front();
                        if (e !== {16'(cyc), 11'(ex), 11'(ey)}) begin
                            errors++;
                            $display("FAIL fetch_pair at (%0d,%0d): got due cycle %0d pixel (%0d,%0d) expected cycle %0d",
                                     ex, ey, e[37:22], e[21:11], e[10:0], cyc);
                        end
                    end
                end
            end
            if (frame_start === 1'b1) fs_cnt++;
            if (fetch_req === 1'b1) exp_q.push_back({16'(cyc + S_LEAD), fetch_x, fetch_y});
        end
        checks++;
        if (de_cnt != 2 * S_HA * S_VA || fs_cnt != 2) begin
            errors++; $display("FAIL frame_counts: de=%0d fs=%0d expected %0d 2", de_cnt, fs_cnt, 2 * S_HA * S_VA);
        end
        checks++;
        if (exp_q.size() != 2) begin
            errors++; $display("FAIL frame_tail_size: got %0d expected 2", exp_q.size());
        end else if (exp_q[0] !== {16'(2 * S_FRAME), 11'd0, 11'd0} || exp_q[1] !== {16'(2 * S_FRAME + 1), 11'd1, 11'd0}) begin
            errors++; $display("FAIL frame_tail: got %h %h expected next frame (0,0),(1,0)", exp_q[0], exp_q[1]);
        end
        exp_q.delete();
    endtask

    // Lock drop sampled on the edge that presents (5,2).
    task automatic test_lock_drop();
        bit found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (pos_x === 11'd4 && pos_y === 11'd2) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL drop_wait: got timeout expected (4,2)"); end
        pll_locked = 1'b0;
        @(negedge clk);
        checks++;
        if (running !== 1'b1 || pos_x !== 11'd5 || pos_y !== 11'd2) begin
            errors++; $display("FAIL drop_cycle0: run=%b pos=(%0d,%0d) expected 1 (5,2)", running, pos_x, pos_y);
        end
        @(negedge clk);
        checks++;
        if (running !== 1'b1 || pos_x !== 11'd6) begin
            errors++; $display("FAIL drop_cycle1: run=%b x=%0d expected 1 6", running, pos_x);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (small_vec !== RST_VEC) begin
                errors++; $display("FAIL drop_reset %0d: got %h expected %h", i, small_vec, RST_VEC);
            end
        end
        pll_locked = 1'b1;
        for (int k = 1; k <= 2 + S_LOCK; k++) begin
            @(negedge clk);
            if (k < 2 + S_LOCK) begin
                checks++;
                if (running !== 1'b0) begin errors++; $display("FAIL relock_wait %0d: got %b expected 0", k, running); end
            end
        end
        checks++;
        if (running !== 1'b1 || frame_start !== 1'b1 || pos_x !== 11'd0 || pos_y !== 11'd0) begin
            errors++; $display("FAIL relock_start: run=%b fs=%b pos=(%0d,%0d) expected 1 1 (0,0)",
                               running, frame_start, pos_x, pos_y);
        end
    endtask

    task automatic test_enable_off();
        bit found = 0;
        repeat (20) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (running !== 1'b1 || pos_x !== 11'd7 || pos_y !== 11'd1) begin
            errors++; $display("FAIL enoff_mid: run=%b pos=(%0d,%0d) expected 1 (7,1)", running, pos_x, pos_y);
        end
        for (int i = 0; i < 150 && !found; i++) begin
            @(negedge clk);
            if (pos_x === 11'(S_HT - 1) && pos_y === 11'(S_VT - 1) && running === 1'b1) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL enoff_wait: got timeout expected frame end"); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (small_vec !== RST_VEC) begin
                errors++; $display("FAIL enoff_idle %0d: got %h expected %h", i, small_vec, RST_VEC);
            end
        end
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (running !== 1'b1 || frame_start !== 1'b1 || pos_x !== 11'd0 || pos_y !== 11'd0) begin
            errors++; $display("FAIL enon_start: run=%b fs=%b pos=(%0d,%0d) expected 1 1 (0,0)",
                               running, frame_start, pos_x, pos_y);
        end
        @(negedge clk);
        checks++;
        if (pos_x !== 11'd1 || frame_start !== 1'b0) begin
            errors++; $display("FAIL enon_next: x=%0d fs=%b expected 1 0", pos_x, frame_start);
        end
    endtask

    task automatic test_reset_mid_frame();
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (small_vec !== RST_VEC) begin
                errors++; $display("FAIL midreset %0d: got %h expected %h", i, small_vec, RST_VEC);
            end
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 2 + S_LOCK; k++) begin
            @(negedge clk);
            if (k < 2 + S_LOCK) begin
                checks++;
                if (running !== 1'b0) begin errors++; $display("FAIL midreset_wait %0d: got %b expected 0", k, running); end
            end
        end
        checks++;
        if (running !== 1'b1 || frame_start !== 1'b1 || pos_x !== 11'd0 || pos_y !== 11'd0) begin
            errors++; $display("FAIL midreset_restart: run=%b fs=%b pos=(%0d,%0d) expected 1 1 (0,0)",
                               running, frame_start, pos_x, pos_y);
        end
    endtask

    // Default 1024x768 timing: lock qualification and the whole of line 0.
    task automatic test_default_line();
        int n, de_cnt, hs_cnt, hs_first, hs_last, vs_bad, pos_bad;
        n = 0; de_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; vs_bad = 0; pos_bad = 0;
        pll_locked_d = 1'b1;
        for (int i = 1; i <= 1100 && n == 0; i++) begin
            @(negedge clk);
            if (running_d === 1'b1) n = i;
        end
        checks++;
        if (n != 1026) begin errors++; $display("FAIL def_lock_time: got %0d expected 1026", n); end
        checks++;
        if (frame_start_d !== 1'b1 || pos_x_d !== 11'd0 || pos_y_d !== 11'd0) begin
            errors++; $display("FAIL def_start: fs=%b pos=(%0d,%0d) expected 1 (0,0)", frame_start_d, pos_x_d, pos_y_d);
        end
        for (int x = 0; x < 1344; x++) begin
            if (x > 0) @(negedge clk);
            if (pos_x_d !== 11'(x) || pos_y_d !== 11'd0) pos_bad++;
            if (de_d === 1'b1) de_cnt++;
            if (vsync_d !== 1'b1) vs_bad++;
            if (hsync_d === 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = x;
                hs_last = x;
            end
            if (x == 1342) begin
                checks++;
                if (fetch_req_d !== 1'b1 || fetch_x_d !== 11'd0 || fetch_y_d !== 11'd1) begin
                    errors++; $display("FAIL def_line_fetch: req=%b (%0d,%0d) expected 1 (0,1)",
                                       fetch_req_d, fetch_x_d, fetch_y_d);
                end
            end
        end
        checks++;
        if (pos_bad != 0) begin errors++; $display("FAIL def_pos: got %0d bad cycles expected 0", pos_bad); end
        checks++;
        if (hs_first != 1048 || hs_last != 1183 || hs_cnt != 136) begin
            errors++; $display("FAIL def_hsync: first=%0d last=%0d count=%0d expected 1048 1183 136",
                               hs_first, hs_last, hs_cnt);
        end
        checks++;
        if (de_cnt != 1024) begin errors++; $display("FAIL def_de_count: got %0d expected 1024", de_cnt); end
        checks++;
        if (vs_bad != 0) begin errors++; $display("FAIL def_vsync: got %0d low cycles expected 0", vs_bad); end
        @(negedge clk);
        checks++;
        if (pos_x_d !== 11'd0 || pos_y_d !== 11'd1 || de_d !== 1'b1 || frame_start_d !== 1'b0) begin
            errors++; $display("FAIL def_line_wrap: pos=(%0d,%0d) de=%b fs=%b expected (0,1) 1 0",
                               pos_x_d, pos_y_d, de_d, frame_start_d);
        end
    endtask

    initial begin
        test_reset();
        test_lock_start();
        test_frame();
        test_lock_drop();
        test_enable_off();
        test_reset_mid_frame();
        test_default_line();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
